logic_unit_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one bitwise logic unit (AND/OR/XOR/NOR) among N requesters in the lab datapath. Each requester presents operands and an opcode with a request line. The block grants one requester at a time, captures its operands, runs the shared unit for one cycle and returns a registered result tagged with the requester index. It sits between the per-stage operand sources and the single shared `logic_unit` instance.

---
 rtl/logic_unit_arb_pkg.sv | 15 +
 rtl/logic_unit_arb_logic_unit.sv | 23 ++
 rtl/logic_unit_arb.sv | 152 +++++++++++++++
 tb/tb_logic_unit_arb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arb_pkg.sv
// Shared opcode and state encodings for the round-robin logic-unit arbiter.
package logic_unit_arb_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit_arb_logic_unit.sv
// Shared bitwise logic unit: purely combinational AND/OR/XOR/NOR.
module logic_unit
  import logic_unit_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  // Opcode decode; NOR takes the remaining encoding.
  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/logic_unit_arb.sv
// Round-robin arbiter sharing one logic unit among N requesters.
module logic_unit_arb
  import logic_unit_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned IDW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [2*N-1:0]       op,
  input  logic [N*WIDTH-1:0]   a_in,
  input  logic [N*WIDTH-1:0]   b_in,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [WIDTH-1:0]     res,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic             found_c;
  logic [IDW-1:0]   win_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;
  logic [1:0]       sel_op_c;
  logic [WIDTH-1:0] lu_y;

  // Round-robin winner: first asserted req scanning upward from ptr, wrapping.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found_c && req[idx[IDW-1:0]]) begin
        found_c = 1'b1;
        win_c   = idx[IDW-1:0];
      end
    end
  end

  // Operand/opcode mux for the current winner.
  always_comb begin
    sel_a_c  = '0;
    sel_b_c  = '0;
    sel_op_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_c == IDW'(i)) begin
        sel_a_c  = a_in[i*WIDTH +: WIDTH];
        sel_b_c  = b_in[i*WIDTH +: WIDTH];
        sel_op_c = op[2*i +: 2];
      end
    end
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (lu_y)
  );

  // Sequencer next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    gnt_d       = '0;
    res_d       = res_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          state_d = S_EXEC;
          win_d   = win_c;
          a_d     = sel_a_c;
          b_d     = sel_b_c;
          op_d    = sel_op_c;
          gnt_d   = N'(1) << win_c;
        end
      end
      S_EXEC: begin
        state_d     = S_DONE;
        res_d       = lu_y;
        res_id_d    = win_q;
        res_valid_d = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (win_q == IDW'(N - 1)) ptr_d = '0;
        else                      ptr_d = win_q + IDW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_logic_unit_arb.sv
// Directed self-checking bench for logic_unit_arb.
module tb_logic_unit_arb;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic             busy;
  logic [W-1:0]     res;
  logic             res_valid;
  logic [IDW-1:0]   res_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_arb #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res(res), .res_valid(res_valid), .res_id(res_id)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; op = '0; a_in = '0; b_in = '0;
    step(); step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 0", res); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    a_in[0 +: W] = 32'hF0F0_F0F0;
    b_in[0 +: W] = 32'hFF00_FF00;
    op[1:0]      = 2'b00;
    req          = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec: got %b want 1", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_rv_exec: got %b want 0", res_valid); end
    req = '0;
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_rv: got %b want 1", res_valid); end
    checks++; if (res !== 32'hF000_F000) begin errors++; $display("FAIL single_res: got %h want f000f000", res); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_res_id: got %0d want 0", res_id); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_done: got %b want 0000", gnt); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_rv_idle: got %b want 0", res_valid); end
    checks++; if (res !== 32'hF000_F000) begin errors++; $display("FAIL single_res_hold: got %h want f000f000", res); end
  endtask

  task automatic test_opcodes;
    logic [W-1:0] exp [4];
    exp[0] = 32'h0000_00FF; exp[1] = 32'h00FF_FFFF;
    exp[2] = 32'h00FF_FF00; exp[3] = 32'hFF00_0000;
    a_in[2*W +: W] = 32'h0000_FFFF;
    b_in[2*W +: W] = 32'h00FF_00FF;
    for (int k = 0; k < 4; k++) begin
      op[5:4] = 2'(k);
      req     = 4'b0100;
      step();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL op%0d_gnt: got %b want 0100", k, gnt); end
      req = '0;
      step();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL op%0d_rv: got %b want 1", k, res_valid); end
      checks++; if (res !== exp[k]) begin errors++; $display("FAIL op%0d_res: got %h want %h", k, res, exp[k]); end
      checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL op%0d_res_id: got %0d want 2", k, res_id); end
      step();
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] eg;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int t = 0; t < 13; t++) begin
      step();
      eg = (t % 3 == 0) ? (4'b0001 << ((t / 3) % 4)) : 4'b0000;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt_t%0d: got %b want %b", t, gnt, eg); end
      if (t % 3 == 1) begin
        checks++;
        if (res_id !== 2'((t / 3) % 4)) begin
          errors++; $display("FAIL rr_res_id_t%0d: got %0d want %0d", t, res_id, (t / 3) % 4);
        end
      end
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_wrap;
    req = 4'b1000;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b want 1000", gnt); end
    req = '0;
    step(); step();
    req = 4'b1001;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
    req = '0;
    step(); step();
  endtask

  task automatic test_ignored;
    req = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ign_gnt: got %b want 0001", gnt); end
    req = 4'b0110;
    step();
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL ign_res_id: got %0d want 0", res_id); end
    step();
    req = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_idle: got %b want 0", busy); end
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ign_no_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy); end
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ign_no_gnt2: got %b want 0000", gnt); end
  endtask

  task automatic test_reset_mid;
    req = 4'b1111;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_gnt_pre: got %b want 0010", gnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rm_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rm_res: got %h want 0", res); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_rv: got %b want 0", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rm_res_id: got %0d want 0", res_id); end
    step(); step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rv: got %b want 0", res_valid); end
    rst_n = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_first_gnt: got %b want 0001", gnt); end
    req = '0;
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rm_rv_after: got %b want 1", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rm_res_id_after: got %0d want 0", res_id); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_round_robin();
    test_wrap();
    test_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
